// File: rtl/hamming_pkg.sv
// Shared constants and types for the extended-Hamming (8,4) SECDED decoder.
package hamming_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D1_POS = 2;
  localparam int P3_POS = 3;
  localparam int D2_POS = 4;
  localparam int D3_POS = 5;
  localparam int D4_POS = 6;
  localparam int P4_POS = 7;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    DOUBLE
  } dec_status_e;

endpackage

// File: rtl/hamming_decoder_if.sv
// Codeword-in / decoded-data-out handshake bundle of the Hamming decoder.
interface hamming_decoder_if;
  import hamming_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              single_err;
  logic              double_err;
  logic [SYN_W-1:0]  err_syn;

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, single_err, double_err, err_syn
  );

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, single_err, double_err, err_syn
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome {s3,s2,s1} and overall parity of an 8-bit codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              p_o
);

  assign syn_o[0] = ^{code_i[P1_POS], code_i[D1_POS], code_i[D2_POS], code_i[D4_POS]};
  assign syn_o[1] = ^{code_i[P2_POS], code_i[D1_POS], code_i[D3_POS], code_i[D4_POS]};
  assign syn_o[2] = ^{code_i[P3_POS], code_i[D2_POS], code_i[D3_POS], code_i[D4_POS]};
  assign p_o      = ^code_i;

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage SECDED decoder with ready/valid flow control.
// Error counters are built only when HAMMING_DEC_CNT_EN is defined.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  hamming_decoder_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic              adv;
  logic [SYN_W-1:0]  syn_in;
  logic              p_in;

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [SYN_W-1:0]  s1_syn_q;
  logic              s1_p_q;

  logic              ov_q;
  logic [DATA_W-1:0] data_q;
  logic              single_q;
  logic              double_q;
  logic [SYN_W-1:0]  syn_q;

  dec_status_e       status_d;
  logic [CODE_W-1:0] flip_d;
  logic [CODE_W-1:0] fixed_d;
  logic [DATA_W-1:0] data_d;
  logic              unused_par;

  // Both stages share one advance so a stalled output freezes the whole pipe.
  assign adv          = ~ov_q | bus.out_ready;
  assign bus.in_ready = adv;

  hamming_syndrome u_syndrome (
    .code_i (bus.code_in),
    .syn_o  (syn_in),
    .p_o    (p_in)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_p_q     <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_code_q  <= bus.code_in;
      s1_syn_q   <= syn_in;
      s1_p_q     <= p_in;
    end
  end

  always_comb begin
    status_d = NONE;
    flip_d   = '0;
    if (s1_p_q) begin
      status_d = SINGLE;
      if (s1_syn_q != '0) flip_d = CODE_W'(1) << (s1_syn_q - SYN_W'(1));
    end else if (s1_syn_q != '0) begin
      status_d = DOUBLE;
    end
    fixed_d = s1_code_q ^ flip_d;
    data_d  = {fixed_d[D4_POS], fixed_d[D3_POS], fixed_d[D2_POS], fixed_d[D1_POS]};
  end

  assign unused_par = ^{fixed_d[P1_POS], fixed_d[P2_POS], fixed_d[P3_POS], fixed_d[P4_POS]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ov_q     <= 1'b0;
      data_q   <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      syn_q    <= '0;
    end else if (adv) begin
      ov_q     <= s1_valid_q;
      data_q   <= data_d;
      single_q <= (status_d == SINGLE);
      double_q <= (status_d == DOUBLE);
      syn_q    <= s1_syn_q;
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.data_out   = data_q;
  assign bus.single_err = single_q;
  assign bus.double_err = double_q;
  assign bus.err_syn    = syn_q;

`ifdef HAMMING_DEC_CNT_EN
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;

  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (ov_q && bus.out_ready) begin
      if (single_q && corr_q != '1)   corr_d   = corr_q + CNT_W'(1);
      if (double_q && uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the error counters.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 code_in  in  8  codeword; bit map [0]=P1 [1]=P2 [2]=D1 [3]=P3 [4]=D2 [5]=D3 [6]=D4 [7]=overall parity P4.
REQ-005 in_valid  in  1  code_in is valid.
REQ-006 in_ready  out  1  decoder accepts code_in this cycle.
REQ-007 data_out  out  4  decoded data {D4,D3,D2,D1}.
REQ-008 out_valid  out  1  data_out and flags are valid.
REQ-009 out_ready  in  1  consumer accepts the output.
REQ-010 single_err  out  1  a single-bit error was detected and corrected.
REQ-011 double_err  out  1  an uncorrectable double-bit error was detected.
REQ-012 err_syn  out  3  syndrome {s3,s2,s1} of the output word.
REQ-013 cnt_clr  in  1  synchronous clear pulse for the counters.
REQ-014 corr_cnt, uncorr_cnt  out  CNT_W each  saturating counts of corrected and uncorrectable words.

Function
REQ-015 s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s3=c3^c4^c5^c6, p=XOR of c[7:0].
REQ-016 syn=0, p=0: no error; data passes through; both flags 0.
REQ-017 syn!=0, p=1: single error at codeword position syn (bit index syn-1) is inverted before extraction; single_err=1.
REQ-018 syn=0, p=1: error in P4 only; data unchanged; single_err=1.
REQ-019 syn!=0, p=0: double_err=1; data_out carries uncorrected D bits; single_err=0.
REQ-020 Two register stages: S1 holds the codeword, syndrome and p; S2 holds the corrected data, flags and err_syn.
REQ-021 Latency is exactly 2 cycles from the in_valid&in_ready edge to out_valid with no backpressure; throughput is 1 word/cycle.
REQ-022 Pipeline advance adv = ~out_valid | out_ready; in_ready = adv; S1 and S2 load only when adv=1.
REQ-023 While out_valid=1 and out_ready=0, data_out, flags and err_syn are held stable.
REQ-024 Bubbles advance with the pipe; no word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 Counters increment on the out_valid&out_ready cycle: corr_cnt if single_err, uncorr_cnt if double_err; they saturate at all-ones.
REQ-026 cnt_clr zeroes both counters next edge; clear wins over a simultaneous increment.

Reset
REQ-027 rstn low forces out_valid=0, S1 valid=0, data_out=0, single_err=0, double_err=0, err_syn=0 and both counters to 0, independent of clk.
REQ-028 Reset mid-operation discards in-flight words; the first word accepted after release appears 2 cycles later.
REQ-029 in_ready reads 1 while in reset and after reset release, since out_valid=0.

Configuration
REQ-030 Macro HAMMING_DEC_CNT_EN defined: counters and cnt_clr logic are built per REQ-025/026.
REQ-031 Macro undefined: no counter flops; corr_cnt and uncorr_cnt are tied to 0; cnt_clr is ignored; all other behaviour is identical.

Structure
REQ-032 Package hamming_pkg holds CODE_W=8, DATA_W=4, SYN_W=3, the bit-position constants of REQ-004 and a decode-status typedef {NONE,SINGLE,DOUBLE}.
REQ-033 Sub-module hamming_syndrome: combinational, code[7:0] -> syn[2:0], p; instantiated once in front of S1.

Verification
REQ-034 Data 4'b1011 encodes as code 8'h55; input 8'h55 -> data_out=4'hB, no flags, err_syn=0, out_valid 2 cycles after accept.
REQ-035 Input 8'h45 (bit 4 flipped) -> data_out=4'hB, single_err=1, err_syn=3'd5, corr_cnt +1.
REQ-036 Inputs 8'hD5 (P4 flipped) -> data_out=4'hB, single_err=1, err_syn=0; 8'h56 (bits 0,1 flipped) -> double_err=1, err_syn=3'd3, uncorr_cnt +1.
REQ-037 Stream 8'h00, 8'h55, 8'h45 with out_ready low for 3 cycles mid-stream -> outputs held, in_ready=0 while stalled, order 0,B,B preserved with no loss.
REQ-038 Drive 300 single-error words with HAMMING_DEC_CNT_EN defined -> corr_cnt saturates at 8'hFF; then cnt_clr together with a single-error word -> corr_cnt=0.
REQ-039 Assert rstn low with 2 words in flight -> out_valid=0 at once; no stale word appears after release.
